// File: rtl/erasure_polyn_sched_pkg.sv
// erasure_polyn_sched_pkg: shared GF(2^8) constants and sequencer state encoding
package erasure_polyn_sched_pkg;
  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam int NUM_COEFS = 16;
  typedef enum logic [2:0] {IDLE, COLLECT, FETCH, UPDATE, DONE} state_t;
endpackage

// File: rtl/erasure_polyn_sched_gf_mult8.sv
// gf_mult8: combinational GF(2^8) multiplier over x^8+x^4+x^3+x^2+1
module gf_mult8
  import erasure_polyn_sched_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] aa;
  always_comb begin
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? aa : 8'h00);
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? GF_POLY : 8'h00);
    end
  end
endmodule

// File: rtl/erasure_polyn_sched.sv
// erasure_polyn_sched: buffers erasure locators, builds Lambda(x) with one shared
// GF multiplier, then serves the coefficients on request.
module erasure_polyn_sched #(
  parameter int WIDTH = 5,
  parameter int NUM_COEFS = erasure_polyn_sched_pkg::NUM_COEFS,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       erase_position,
  input  logic             erase_position_valid,
  output logic             erase_position_ready,
  input  logic             erase_pos_done,
  input  logic [WIDTH-1:0] number_of_erasures,
  input  logic [WIDTH-1:0] no_of_parity,
  input  logic             send_erasure_polyn,
  output logic [7:0]       erasure_loc_polyn,
  output logic [WIDTH-1:0] erase_coef_addr,
  output logic             erasure_coef_ready,
  output logic [WIDTH-1:0] no_of_erasure_coefs,
  output logic             erasure_polyn_compute_done,
  output logic             erasure_error,
  output logic             busy
);
  import erasure_polyn_sched_pkg::*;
  localparam int AW = $clog2(NUM_COEFS);
  localparam int FW = $clog2(FIFO_DEPTH);
  state_t state, state_n;
  logic [7:0] lam [NUM_COEFS];
  logic [7:0] fifo [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0] count;
  logic [WIDTH-1:0] m, acc;
  logic [AW-1:0] k, km1, rd_addr;
  logic [7:0] x, prod;
  logic done_seen, overflow, push, pop, over, empty, full, active;
  assign empty = count == '0;
  assign full = count == (FW+1)'(FIFO_DEPTH);
  assign km1 = k - AW'(1);
  // acc counts locators already enqueued, so the limit holds before they are popped
  assign over = (({1'b0, acc} + (WIDTH+1)'(1)) > {1'b0, no_of_parity}) ||
                (({1'b0, acc} + (WIDTH+1)'(1)) > (WIDTH+1)'(NUM_COEFS - 1));
  assign push = erase_position_valid && erase_position_ready && !over && !start;
  assign pop = (state == COLLECT || state == FETCH) && !empty && !start;
  assign no_of_erasure_coefs = m;
  gf_mult8 u_mul (.a(x), .b(lam[km1]), .p(prod));
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      COLLECT, FETCH: state_n = !empty ? UPDATE : done_seen ? DONE : COLLECT;
      UPDATE: state_n = k != AW'(1) ? UPDATE : !empty ? FETCH : COLLECT;
      default: state_n = state;
    endcase
    if (start) state_n = COLLECT;
  end
  always_comb begin
    active = state inside {COLLECT, FETCH, UPDATE};
    erase_position_ready = active && !full;
  end
  always_ff @(posedge clock) if (push) fifo[wr_ptr] <= erase_position;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_COEFS; i++) lam[i] <= (i == 0) ? 8'h01 : 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      m <= '0;
      acc <= '0;
      k <= '0;
      x <= '0;
      done_seen <= 1'b0;
      overflow <= 1'b0;
      rd_addr <= '0;
      erasure_error <= 1'b0;
      erase_coef_addr <= '0;
      erasure_loc_polyn <= '0;
      erasure_coef_ready <= 1'b0;
      busy <= 1'b0;
      erasure_polyn_compute_done <= 1'b0;
    end else begin
      busy <= state_n inside {COLLECT, FETCH, UPDATE};
      erasure_polyn_compute_done <= state_n == DONE;
      if (start) begin
        for (int i = 0; i < NUM_COEFS; i++) lam[i] <= (i == 0) ? 8'h01 : 8'h00;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        m <= '0;
        acc <= '0;
        k <= '0;
        x <= '0;
        done_seen <= 1'b0;
        overflow <= 1'b0;
        rd_addr <= '0;
        erasure_error <= 1'b0;
        erase_coef_addr <= '0;
        erasure_loc_polyn <= '0;
        erasure_coef_ready <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + FW'(1);
          acc <= acc + WIDTH'(1);
        end
        if (erase_position_valid && erase_position_ready && over) begin
          overflow <= 1'b1;
          erasure_error <= 1'b1;
        end
        count <= count + (FW+1)'(push) - (FW+1)'(pop);
        if (pop) begin
          x <= fifo[rd_ptr];
          rd_ptr <= rd_ptr + FW'(1);
          m <= m + WIDTH'(1);
          k <= AW'(m) + AW'(1);
        end
        // descending k keeps Lambda_{k-1} unmodified when Lambda_k consumes it
        if (state == UPDATE) begin
          lam[k] <= lam[k] ^ prod;
          k <= km1;
        end
        if (erase_pos_done && active) done_seen <= 1'b1;
        if (state != DONE && state_n == DONE && !overflow && m != number_of_erasures)
          erasure_error <= 1'b1;
        erasure_coef_ready <= state == DONE && send_erasure_polyn;
        if (state == DONE && send_erasure_polyn) begin
          erasure_loc_polyn <= lam[rd_addr];
          erase_coef_addr <= WIDTH'(rd_addr);
          rd_addr <= rd_addr + AW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_erasure_polyn_sched.sv
// tb_erasure_polyn_sched: directed vectors with hand-computed Lambda coefficients
module tb_erasure_polyn_sched;
  logic clock = 0, reset = 0, start = 0;
  logic [7:0] erase_position = 0;
  logic erase_position_valid = 0, erase_position_ready, erase_pos_done = 0;
  logic [4:0] number_of_erasures = 0, no_of_parity = 0;
  logic send_erasure_polyn = 0;
  logic [7:0] erasure_loc_polyn;
  logic [4:0] erase_coef_addr, no_of_erasure_coefs;
  logic erasure_coef_ready, erasure_polyn_compute_done, erasure_error, busy;
  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_lam [16];

  always #5 clock = ~clock;

  erasure_polyn_sched dut (
    .clock(clock), .reset(reset), .start(start),
    .erase_position(erase_position), .erase_position_valid(erase_position_valid),
    .erase_position_ready(erase_position_ready), .erase_pos_done(erase_pos_done),
    .number_of_erasures(number_of_erasures), .no_of_parity(no_of_parity),
    .send_erasure_polyn(send_erasure_polyn), .erasure_loc_polyn(erasure_loc_polyn),
    .erase_coef_addr(erase_coef_addr), .erasure_coef_ready(erasure_coef_ready),
    .no_of_erasure_coefs(no_of_erasure_coefs),
    .erasure_polyn_compute_done(erasure_polyn_compute_done),
    .erasure_error(erasure_error), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [4:0] ne, input logic [4:0] np);
    @(negedge clock);
    number_of_erasures = ne;
    no_of_parity = np;
    start = 1;
    @(negedge clock);
    start = 0;
  endtask

  task automatic push(input logic [7:0] v, input logic last);
    int t = 0;
    erase_position = v;
    erase_position_valid = 1;
    while (!erase_position_ready && t < 64) begin
      @(negedge clock);
      t++;
    end
    if (t == 64) check("push_ready", erase_position_ready, 1);
    erase_pos_done = last;
    @(negedge clock);
    erase_position_valid = 0;
    erase_pos_done = 0;
  endtask

  task automatic pulse_done();
    erase_pos_done = 1;
    @(negedge clock);
    erase_pos_done = 0;
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    while (!erasure_polyn_compute_done && n < 500) begin
      @(negedge clock);
      n++;
    end
    check(tag, n, exp_n);
  endtask

  task automatic set_exp(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    for (int i = 0; i < 16; i++) exp_lam[i] = 8'h00;
    exp_lam[0] = c0;
    exp_lam[1] = c1;
    exp_lam[2] = c2;
  endtask

  task automatic read_coefs(input string tag, input int n);
    send_erasure_polyn = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check($sformatf("%s_rdy%0d", tag, i), erasure_coef_ready, 1);
      check($sformatf("%s_addr%0d", tag, i), erase_coef_addr, i % 16);
      check($sformatf("%s_coef%0d", tag, i), erasure_loc_polyn, exp_lam[i % 16]);
    end
    send_erasure_polyn = 0;
    @(negedge clock);
    check({tag, "_rdy_off"}, erasure_coef_ready, 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1;
    @(negedge clock);
    check("rst_ready", erase_position_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", erasure_polyn_compute_done, 0);
    check("rst_err", erasure_error, 0);
    check("rst_cready", erasure_coef_ready, 0);
    check("rst_m", no_of_erasure_coefs, 0);
    check("rst_addr", erase_coef_addr, 0);
    check("rst_coef", erasure_loc_polyn, 0);
    send_erasure_polyn = 1;
    @(negedge clock);
    check("idle_req_ignored", erasure_coef_ready, 0);
    send_erasure_polyn = 0;

    do_start(0, 16);
    check("t1_busy", busy, 1);
    check("t1_not_done", erasure_polyn_compute_done, 0);
    pulse_done();
    wait_done("t1_latency", 1);
    check("t1_m", no_of_erasure_coefs, 0);
    check("t1_err", erasure_error, 0);
    check("t1_busy_off", busy, 0);
    check("t1_ready_done", erase_position_ready, 0);
    set_exp(8'h01, 8'h00, 8'h00);
    read_coefs("t1", 3);

    do_start(1, 16);
    check("t2_done_drop", erasure_polyn_compute_done, 0);
    push(8'h02, 1);
    wait_done("t2_latency", 3);
    check("t2_m", no_of_erasure_coefs, 1);
    check("t2_err", erasure_error, 0);
    set_exp(8'h01, 8'h02, 8'h00);
    read_coefs("t2", 3);

    do_start(2, 16);
    push(8'h02, 0);
    push(8'h04, 1);
    wait_done("t3_latency", 5);
    check("t3_m", no_of_erasure_coefs, 2);
    check("t3_err", erasure_error, 0);
    set_exp(8'h01, 8'h06, 8'h08);
    read_coefs("t3", 4);

    do_start(3, 2);
    push(8'h02, 0);
    push(8'h04, 0);
    check("t4_err_before", erasure_error, 0);
    push(8'h08, 1);
    check("t4_err_ovf", erasure_error, 1);
    wait_done("t4_latency", 4);
    check("t4_m", no_of_erasure_coefs, 2);
    check("t4_err_final", erasure_error, 1);
    set_exp(8'h01, 8'h06, 8'h08);
    read_coefs("t4", 4);

    do_start(2, 16);
    push(8'h02, 1);
    wait_done("mis_latency", 3);
    check("mis_m", no_of_erasure_coefs, 1);
    check("mis_err", erasure_error, 1);

    do_start(15, 16);
    for (int i = 0; i < 15; i++) push(8'h01, 0);
    check("t5_err_at_limit", erasure_error, 0);
    push(8'h01, 0);
    check("t5_err_ovf", erasure_error, 1);
    push(8'h01, 1);
    wait_done("t5_latency", 120);
    check("t5_m", no_of_erasure_coefs, 15);
    check("t5_err_final", erasure_error, 1);
    for (int i = 0; i < 16; i++) exp_lam[i] = 8'h01;
    read_coefs("t5", 16);

    do_start(5, 16);
    push(8'h55, 0);
    push(8'h77, 0);
    push(8'h99, 0);
    do_start(1, 16);
    check("t6_busy", busy, 1);
    check("t6_err_clr", erasure_error, 0);
    check("t6_m_clr", no_of_erasure_coefs, 0);
    push(8'h03, 1);
    wait_done("t6_latency", 3);
    check("t6_m", no_of_erasure_coefs, 1);
    check("t6_err", erasure_error, 0);
    set_exp(8'h01, 8'h03, 8'h00);
    read_coefs("t6", 17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
